// File: rtl/bp_be_pkg.sv
// Shared backend declarations: the core configuration, the frontend branch metadata, and the
// frontend command generator FSM states.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg
    } bp_params_e;

    localparam int unsigned vaddr_width_gp = 39;
    localparam int unsigned fetch_ptr_gp   = 2;

    // Frontend metadata carried with each fetched instruction and returned on resolution
    typedef struct packed {
        logic [7:0] ghist;
        logic [7:0] bht_idx;
        logic       src_ras;
        logic       src_btb;
        logic       site_jalr;
        logic       site_jal;
        logic       site_br;
    } bp_fe_branch_metadata_fwd_s;

    localparam int unsigned branch_metadata_fwd_width_gp = $bits(bp_fe_branch_metadata_fwd_s);

    typedef enum logic [1:0] {
        e_init,
        e_run,
        e_flush
    } bp_be_fe_cmd_gen_state_e;

    function automatic int unsigned bp_vaddr_width(bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_attaboy_fifo.sv
// Attaboy queue: power-of-two circular buffer with an extra pointer bit to tell full from
// empty, a combinational head, and a single-cycle clear.
module bp_be_attaboy_fifo #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clr_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned PtrW = $clog2(els_p);

    logic [PtrW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [width_p-1:0]   mem_q [els_p];
    logic                 enq, deq;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
        // A pop in the same cycle frees the slot the write lands in
        enq     = v_i & (~full_o | yumi_i) & ~clr_i;
        deq     = yumi_i & ~empty_o;
        data_o  = mem_q[rptr_q[PtrW-1:0]];
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (enq) wptr_d = wptr_q + 1'b1;
            if (deq) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q[PtrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_be_fe_cmd_gen.sv
// Backend-to-frontend command generator: turns branch resolutions into registered redirects
// on mispredict and queued attaboys (training hints) on correct predictions.
module bp_be_fe_cmd_gen
    import bp_be_pkg::*;
#(
    parameter bp_params_e  bp_params_p                 = e_bp_default_cfg,
    parameter int unsigned queue_els_p                 = 4,
    parameter int unsigned force_age_p                 = 15,
    parameter int unsigned vaddr_width_p               = bp_vaddr_width(bp_params_p),
    parameter int unsigned branch_metadata_fwd_width_p = branch_metadata_fwd_width_gp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   fe_init_done_i,

    input  logic                                   res_v_i,
    input  logic [vaddr_width_p-1:0]               res_pc_i,
    input  logic [vaddr_width_p-1:0]               res_npc_i,
    input  logic [vaddr_width_p-1:0]               res_pred_npc_i,
    input  logic [fetch_ptr_gp-1:0]                res_count_i,
    input  logic [branch_metadata_fwd_width_p-1:0] res_metadata_i,
    input  logic                                   res_taken_i,

    output logic                                   redirect_v_o,
    output logic [vaddr_width_p-1:0]               redirect_npc_o,
    output logic [vaddr_width_p-1:0]               redirect_pc_o,
    output logic [fetch_ptr_gp-1:0]                redirect_count_o,
    output logic                                   redirect_br_v_o,
    output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
    output logic                                   redirect_br_taken_o,
    output logic                                   redirect_br_ntaken_o,
    output logic                                   redirect_br_nonbr_o,

    output logic                                   attaboy_v_o,
    output logic [vaddr_width_p-1:0]               attaboy_pc_o,
    output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
    output logic                                   attaboy_taken_o,
    output logic                                   attaboy_ntaken_o,
    output logic                                   attaboy_force_o,
    input  logic                                   attaboy_yumi_i,

    output logic [7:0]                             drop_count_o
);

    localparam int unsigned EntryW = vaddr_width_p + branch_metadata_fwd_width_p + 1;
    localparam int unsigned AgeW   = $clog2(force_age_p + 1);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(force_age_p);

    typedef struct packed {
        logic                                   v;
        logic                                   br_v;
        logic                                   taken;
        logic                                   ntaken;
        logic                                   nonbr;
        logic [vaddr_width_p-1:0]               npc;
        logic [vaddr_width_p-1:0]               pc;
        logic [fetch_ptr_gp-1:0]                count;
        logic [branch_metadata_fwd_width_p-1:0] meta;
    } redirect_t;

    bp_be_fe_cmd_gen_state_e    state_q, state_d;
    redirect_t                  redirect_q, redirect_d;
    logic [AgeW-1:0]            age_q, age_d;
    logic [7:0]                 drop_q, drop_d;

    bp_fe_branch_metadata_fwd_s meta;
    logic                       run, any_site, mispredict, enq_req, pop, drop, attaboy_v;
    logic                       q_empty, q_full;
    logic [EntryW-1:0]          enq_data, head_data;

    always_comb begin
        meta       = res_metadata_i;
        run        = (state_q == e_run);
        any_site   = meta.site_br | meta.site_jal | meta.site_jalr;
        mispredict = run & res_v_i & (res_npc_i != res_pred_npc_i);
        enq_req    = run & res_v_i & ~mispredict & any_site;
        attaboy_v  = ~q_empty & run;
        pop        = attaboy_v & attaboy_yumi_i;
        drop       = enq_req & q_full & ~pop;
        enq_data   = {res_pc_i, meta, res_taken_i};
    end

    bp_be_attaboy_fifo #(
        .els_p   (queue_els_p),
        .width_p (EntryW)
    ) u_attaboy_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (mispredict),
        .v_i       (enq_req),
        .data_i    (enq_data),
        .yumi_i    (pop),
        .data_o    (head_data),
        .empty_o   (q_empty),
        .full_o    (q_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_init:  if (fe_init_done_i) state_d = e_run;
            e_run:   if (mispredict) state_d = e_flush;
            e_flush: state_d = e_run;
            default: state_d = e_init;
        endcase
    end

    always_comb begin
        redirect_d        = redirect_q;
        redirect_d.v      = mispredict;
        redirect_d.br_v   = mispredict & (any_site | meta.src_btb);
        redirect_d.taken  = mispredict & any_site & res_taken_i;
        redirect_d.ntaken = mispredict & meta.site_br & ~res_taken_i;
        redirect_d.nonbr  = mispredict & ~any_site & meta.src_btb;
        if (mispredict) begin
            redirect_d.npc   = res_npc_i;
            redirect_d.pc    = res_pc_i;
            redirect_d.count = res_count_i;
            redirect_d.meta  = meta;
        end
    end

    // Age restarts whenever the head changes or the queue is cleared
    always_comb begin
        age_d = age_q;
        if (mispredict || pop || q_empty) begin
            age_d = '0;
        end else if (attaboy_v && (age_q != AgeMax)) begin
            age_d = age_q + 1'b1;
        end
        drop_d = drop_q;
        if (drop && (drop_q != 8'hff)) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_init;
            redirect_q <= '0;
            age_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            age_q      <= age_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        redirect_v_o               = redirect_q.v;
        redirect_npc_o             = redirect_q.npc;
        redirect_pc_o              = redirect_q.pc;
        redirect_count_o           = redirect_q.count;
        redirect_br_v_o            = redirect_q.br_v;
        redirect_br_metadata_fwd_o = redirect_q.meta;
        redirect_br_taken_o        = redirect_q.taken;
        redirect_br_ntaken_o       = redirect_q.ntaken;
        redirect_br_nonbr_o        = redirect_q.nonbr;

        attaboy_v_o = attaboy_v;
        {attaboy_pc_o, attaboy_br_metadata_fwd_o, attaboy_taken_o} = head_data;
        attaboy_ntaken_o = ~attaboy_taken_o;
        attaboy_force_o  = (age_q == AgeMax) | q_full;
        drop_count_o     = drop_q;
    end

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Bench for bp_be_fe_cmd_gen: directed corner sequences, a redirect-flag vector table, and a
// randomized run, all checked against a queue-based reference model.
module tb_bp_be_fe_cmd_gen;
    import bp_be_pkg::*;

    localparam int unsigned VW       = vaddr_width_gp;
    localparam int unsigned MW       = branch_metadata_fwd_width_gp;
    localparam int unsigned CW       = fetch_ptr_gp;
    localparam int          Depth    = 4;
    localparam int          ForceAge = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic fe_init_done = 1'b0;
    logic res_v = 1'b0;
    logic [VW-1:0] res_pc = '0, res_npc = '0, res_pred_npc = '0;
    logic [CW-1:0] res_count = '0;
    bp_fe_branch_metadata_fwd_s res_meta = '0;
    logic res_taken = 1'b0;
    logic yumi = 1'b0;

    logic          redirect_v, redirect_br_v, redirect_taken, redirect_ntaken, redirect_nonbr;
    logic [VW-1:0] redirect_npc, redirect_pc;
    logic [CW-1:0] redirect_count;
    logic [MW-1:0] redirect_meta;
    logic          attaboy_v, attaboy_taken, attaboy_ntaken, attaboy_force;
    logic [VW-1:0] attaboy_pc;
    logic [MW-1:0] attaboy_meta;
    logic [7:0]    drop_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bp_be_fe_cmd_gen #(
        .queue_els_p (Depth),
        .force_age_p (ForceAge)
    ) dut (
        .clk_i                      (clk),
        .reset_n_i                  (reset_n),
        .fe_init_done_i             (fe_init_done),
        .res_v_i                    (res_v),
        .res_pc_i                   (res_pc),
        .res_npc_i                  (res_npc),
        .res_pred_npc_i             (res_pred_npc),
        .res_count_i                (res_count),
        .res_metadata_i             (res_meta),
        .res_taken_i                (res_taken),
        .redirect_v_o               (redirect_v),
        .redirect_npc_o             (redirect_npc),
        .redirect_pc_o              (redirect_pc),
        .redirect_count_o           (redirect_count),
        .redirect_br_v_o            (redirect_br_v),
        .redirect_br_metadata_fwd_o (redirect_meta),
        .redirect_br_taken_o        (redirect_taken),
        .redirect_br_ntaken_o       (redirect_ntaken),
        .redirect_br_nonbr_o        (redirect_nonbr),
        .attaboy_v_o                (attaboy_v),
        .attaboy_pc_o               (attaboy_pc),
        .attaboy_br_metadata_fwd_o  (attaboy_meta),
        .attaboy_taken_o            (attaboy_taken),
        .attaboy_ntaken_o           (attaboy_ntaken),
        .attaboy_force_o            (attaboy_force),
        .attaboy_yumi_i             (yumi),
        .drop_count_o               (drop_count)
    );

    // Reference model: mode 0 = waiting for init, 1 = running, 2 = one-cycle flush
    typedef struct {
        logic [VW-1:0]              pc;
        bp_fe_branch_metadata_fwd_s meta;
        logic                       taken;
    } ent_t;

    ent_t          mq[$];
    int            m_mode, m_drops, m_age;
    logic          e_rv, e_brv, e_tk, e_ntk, e_nonbr;
    logic [VW-1:0] e_npc, e_pc;
    logic [CW-1:0] e_cnt;
    logic [MW-1:0] e_meta;

    function automatic void model_reset();
        mq.delete();
        m_mode = 0; m_drops = 0; m_age = 0;
        e_rv = 0; e_brv = 0; e_tk = 0; e_ntk = 0; e_nonbr = 0;
    endfunction

    function automatic void model_step();
        bit run  = (m_mode == 1);
        bit any  = res_meta.site_br || res_meta.site_jal || res_meta.site_jalr;
        bit av   = run && (mq.size() > 0);
        bit pop  = av && yumi;
        bit mis  = run && res_v && (res_npc != res_pred_npc);
        bit enq  = run && res_v && !mis && any;
        int sz   = mq.size();
        e_rv    = mis;
        e_brv   = mis && (any || res_meta.src_btb);
        e_tk    = mis && any && res_taken;
        e_ntk   = mis && res_meta.site_br && !res_taken;
        e_nonbr = mis && !any && res_meta.src_btb;
        if (mis) begin
            e_npc = res_npc; e_pc = res_pc; e_cnt = res_count; e_meta = res_meta;
        end
        if (mis || pop || sz == 0) m_age = 0;
        else if (av && m_age < ForceAge) m_age++;
        if (mis) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (enq) begin
                if (sz == Depth && !pop) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    mq.push_back('{res_pc, res_meta, res_taken});
                end
            end
        end
        if (m_mode == 0 && fe_init_done) m_mode = 1;
        else if (m_mode == 1 && mis) m_mode = 2;
        else if (m_mode == 2) m_mode = 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        bit exp_av = (m_mode == 1) && (mq.size() > 0);
        chk("redirect_v", 64'(redirect_v), 64'(e_rv));
        chk("redirect_flags", 64'({redirect_br_v, redirect_taken, redirect_ntaken, redirect_nonbr}),
            64'({e_brv, e_tk, e_ntk, e_nonbr}));
        if (e_rv) begin
            chk("redirect_npc", 64'(redirect_npc), 64'(e_npc));
            chk("redirect_pc", 64'(redirect_pc), 64'(e_pc));
            chk("redirect_count", 64'(redirect_count), 64'(e_cnt));
            chk("redirect_meta", 64'(redirect_meta), 64'(e_meta));
        end
        chk("attaboy_v", 64'(attaboy_v), 64'(exp_av));
        if (exp_av) begin
            chk("attaboy_pc", 64'(attaboy_pc), 64'(mq[0].pc));
            chk("attaboy_meta", 64'(attaboy_meta), 64'(mq[0].meta));
            chk("attaboy_tk", 64'({attaboy_taken, attaboy_ntaken}),
                64'({mq[0].taken, !mq[0].taken}));
        end
        chk("attaboy_force", 64'(attaboy_force),
            64'((m_age == ForceAge) || (mq.size() == Depth)));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; fe_init_done = 1'b0; res_v = 1'b0; yumi = 1'b0;
        #2;
        model_reset();
        chk("rst_redirect_v", 64'(redirect_v), 64'd0);
        chk("rst_attaboy_v", 64'(attaboy_v), 64'd0);
        chk("rst_force", 64'(attaboy_force), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_up();
        fe_init_done = 1'b1; res_v = 1'b0; yumi = 1'b0;
        tick();
    endtask

    task automatic set_res(input logic v, input logic [VW-1:0] pc, input logic [VW-1:0] npc,
                           input logic [VW-1:0] pred, input logic br, input logic jal,
                           input logic jalr, input logic btb, input logic tk);
        res_v = v; res_pc = pc; res_npc = npc; res_pred_npc = pred; res_taken = tk;
        res_count = CW'($urandom());
        res_meta = bp_fe_branch_metadata_fwd_s'(MW'($urandom()));
        res_meta.site_br = br; res_meta.site_jal = jal; res_meta.site_jalr = jalr;
        res_meta.src_btb = btb;
    endtask

    // {site_br, site_jal, site_jalr, src_btb, taken, expected {br_v, taken, ntaken, nonbr}}
    typedef struct packed {
        logic br, jal, jalr, btb, tk;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1001};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100};

        // Held in init: resolutions (good and bad) are ignored
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_res(1'b1, 39'h100, 39'h104, (i % 2 == 0) ? 39'h104 : 39'h200, 1, 0, 0, 0, 1);
            tick();
            chk("init_no_attaboy", 64'(attaboy_v), 64'd0);
            chk("init_no_redirect", 64'(redirect_v), 64'd0);
        end
        fe_init_done = 1'b1;
        set_res(1'b1, 39'h40, 39'h44, 39'h44, 1, 0, 0, 0, 0);
        tick();
        chk("init_edge_ignored", 64'(attaboy_v), 64'd0);
        tick();
        chk("run_after_init", 64'(attaboy_v), 64'd1);
        chk("run_after_init_pc", 64'(attaboy_pc), 64'h40);

        // Mispredicted taken branch
        do_reset();
        run_up();
        set_res(1'b1, 39'h8000_0000, 39'h8000_0040, 39'h8000_0004, 1, 0, 0, 0, 1);
        tick();
        chk("mispred_v", 64'(redirect_v), 64'd1);
        chk("mispred_taken", 64'(redirect_taken), 64'd1);
        chk("mispred_npc", 64'(redirect_npc), 64'h8000_0040);
        res_v = 1'b0;
        tick();
        chk("mispred_pulse", 64'(redirect_v), 64'd0);

        // Five correct branches into a four-deep queue
        do_reset();
        run_up();
        for (int i = 0; i < 5; i++) begin
            set_res(1'b1, VW'(32'h100 + 4 * i), 39'h900, 39'h900, 1, 0, 0, 0, i % 2);
            tick();
        end
        res_v = 1'b0;
        chk("full_force", 64'(attaboy_force), 64'd1);
        chk("full_drop", 64'(drop_count), 64'd1);
        chk("full_head", 64'(attaboy_pc), 64'h100);
        n = 0;
        while (attaboy_v && n < 8) begin
            yumi = 1'b1;
            tick();
            n++;
        end
        yumi = 1'b0;
        chk("full_entries", 64'(n), 64'd4);

        // Head aging
        do_reset();
        run_up();
        set_res(1'b1, 39'h300, 39'h304, 39'h304, 0, 1, 0, 0, 1);
        tick();
        res_v = 1'b0;
        repeat (14) tick();
        chk("age_14", 64'(attaboy_force), 64'd0);
        tick();
        chk("age_15", 64'(attaboy_force), 64'd1);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        chk("age_cleared", 64'(attaboy_force), 64'd0);

        // Mispredict with yumi in the same cycle on a three-entry queue
        do_reset();
        run_up();
        for (int i = 0; i < 3; i++) begin
            set_res(1'b1, VW'(32'h400 + 4 * i), 39'h800, 39'h800, 1, 0, 0, 0, 1);
            tick();
        end
        set_res(1'b1, 39'h420, 39'h500, 39'h424, 1, 0, 0, 0, 1);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        res_v = 1'b0;
        chk("simul_redirect", 64'(redirect_v), 64'd1);
        chk("simul_no_ab_1", 64'(attaboy_v), 64'd0);
        tick();
        chk("simul_no_ab_2", 64'(attaboy_v), 64'd0);
        set_res(1'b1, 39'h500, 39'h504, 39'h504, 1, 0, 0, 0, 0);
        tick();
        res_v = 1'b0;
        chk("simul_fresh_head", 64'(attaboy_pc), 64'h500);

        // Redirect flag decode table
        do_reset();
        run_up();
        for (int i = 0; i < 8; i++) begin
            set_res(1'b1, 39'h600, 39'h700, 39'h604, vecs[i].br, vecs[i].jal, vecs[i].jalr,
                    vecs[i].btb, vecs[i].tk);
            tick();
            chk("vec_v", 64'(redirect_v), 64'd1);
            chk("vec_flags", 64'({redirect_br_v, redirect_taken, redirect_ntaken,
                                  redirect_nonbr}), 64'(vecs[i].exp));
            res_v = 1'b0;
            tick();
        end

        // Reset in the middle of a redirect and a partly filled queue
        for (int i = 0; i < 2; i++) begin
            set_res(1'b1, VW'(32'h700 + 4 * i), 39'h10, 39'h10, 1, 0, 0, 0, 1);
            tick();
        end
        set_res(1'b1, 39'h710, 39'h20, 39'h24, 1, 0, 0, 0, 1);
        tick();
        do_reset();
        run_up();
        chk("rst_discard", 64'(attaboy_v), 64'd0);

        // Randomized traffic with alternating consumer pressure
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            fe_init_done = ($urandom_range(0, 3) != 0);
            res_v = ($urandom_range(0, 9) < 6);
            res_pc = VW'({$urandom(), $urandom()});
            res_npc = VW'({$urandom(), $urandom()});
            res_pred_npc = ($urandom_range(0, 7) == 0) ? VW'($urandom()) : res_npc;
            res_count = CW'($urandom());
            res_meta = bp_fe_branch_metadata_fwd_s'(MW'($urandom()));
            res_taken = 1'($urandom());
            yumi = ((c / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 99) < 15);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_be_fe_cmd_gen.md
BP_BE_FE_CMD_GEN -- requirements
Module: bp_be_fe_cmd_gen

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, meaning processor config (vaddr_width_p, branch_metadata_fwd_width_p).
REQ-002 SHALL have parameter queue_els_p, default 4, meaning attaboy queue depth (power of two, ≥2).
REQ-003 SHALL have parameter force_age_p, default 15, meaning cycles an attaboy head waits before force is raised.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports: clk_i in 1, rising-edge clock; reset_n_i in 1, asynchronous active-low reset.
REQ-005 SHALL have fe_init_done_i in 1, frontend predictors initialised.
REQ-006 SHALL have res_v_i in 1, branch resolution valid (retiring instruction with fetch metadata).
REQ-007 SHALL have res_pc_i in vaddr_width_p, resolved instruction PC.
REQ-008 SHALL have res_npc_i in vaddr_width_p, architecturally correct next PC.
REQ-009 SHALL have res_pred_npc_i in vaddr_width_p, frontend-predicted next PC.
REQ-010 SHALL have res_count_i in fetch_ptr_gp, fetch count of the resolving instruction.
REQ-011 SHALL have res_metadata_i in branch_metadata_fwd_width_p, metadata returned from fetch.
REQ-012 SHALL have res_taken_i in 1, actual taken outcome.
REQ-013 SHALL have redirect_v_o, redirect_npc_o, redirect_pc_o, redirect_count_o, redirect_br_v_o, redirect_br_metadata_fwd_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o as out ports, widths matching the frontend redirect inputs, forming the redirect command.
REQ-014 SHALL have attaboy_v_o out 1, attaboy_pc_o out vaddr_width_p, attaboy_br_metadata_fwd_o out branch_metadata_fwd_width_p, attaboy_taken_o out 1, attaboy_ntaken_o out 1, attaboy_force_o out 1, attaboy_yumi_i in 1, forming the attaboy valid/yumi channel.
REQ-015 SHALL have drop_count_o out 8, saturating count of attaboys dropped on full queue.

Function
REQ-016 SHALL implement FSM states e_init, e_run, e_flush; e_init→e_run when fe_init_done_i=1; e_run→e_flush on mispredict; e_flush→e_run unconditionally after one cycle.
REQ-017 SHALL ignore res_v_i in e_init and e_flush.
REQ-018 SHALL define mispredict as res_v_i & (res_npc_i != res_pred_npc_i) in e_run.
REQ-019 SHALL register all redirect outputs; redirect_v_o pulses exactly one cycle, the cycle after the mispredict.
REQ-020 SHALL set redirect_npc_o=res_npc_i, redirect_pc_o=res_pc_i, redirect_count_o=res_count_i, and metadata passthrough.
REQ-021 SHALL set redirect_br_v_o = redirect_v_o & (site_br|site_jal|site_jalr|src_btb); taken = site jump/branch & res_taken_i; ntaken = site_br & ~res_taken_i; nonbr = ~(site_br|site_jal|site_jalr) & src_btb; at most one of the three is 1.
REQ-022 SHALL enqueue {pc, metadata, taken} when e_run, res_v_i, no mispredict, and any of site_br/site_jal/site_jalr is set.
REQ-023 SHALL drop the enqueue and increment drop_count_o (saturating at 255) when the queue is full and no yumi occurs that cycle; enqueue with simultaneous yumi on a full queue SHALL succeed.
REQ-024 SHALL present the queue head combinationally: attaboy_v_o = ~empty & state==e_run; pop on attaboy_yumi_i; attaboy_ntaken_o = ~attaboy_taken_o.
REQ-025 SHALL keep a head age counter: cleared on pop or empty, incremented per cycle while attaboy_v_o & ~yumi, saturating at force_age_p; attaboy_force_o = (age==force_age_p) | full.
REQ-026 SHALL flush the queue on the cycle the mispredict is detected; a yumi in that same cycle completes the pop first; an enqueue in that cycle is discarded.
REQ-027 SHALL have enqueue-to-attaboy_v_o latency of one cycle.
REQ-028 SHALL handle pointer wrap-around with one extra pointer bit for full/empty.

Reset
REQ-029 SHALL, on reset_n_i low, asynchronously set state e_init, empty queue, zero age, zero drop_count_o, and drive redirect_v_o=0, attaboy_v_o=0, attaboy_force_o=0; reset mid-operation discards all pending commands.

Structure
REQ-030 SHALL place the state enum bp_be_fe_cmd_gen_state_e in bp_be_pkg.
REQ-031 SHALL reuse bp_fe_branch_metadata_fwd_s from the shared core-interface declarations.
REQ-032 SHALL implement the queue as one sub-module, bp_be_attaboy_fifo, with async active-low reset.

Verification
REQ-033 SHALL check init: fe_init_done_i=0 for 10 cycles with res_v_i=1 -> no attaboy_v_o and no redirect_v_o; state enters e_run one cycle after init_done=1.
REQ-034 SHALL check mispredict: res_npc_i=0x8000_0040, res_pred_npc_i=0x8000_0004, site_br, taken=1 -> next cycle redirect_v_o=1, redirect_br_taken_o=1, redirect_npc_o=0x8000_0040, then low.
REQ-035 SHALL check full queue: 5 correct branches, yumi=0 -> 4 queued, force=1, drop_count_o=1.
REQ-036 SHALL check aging: 1 entry, yumi held low -> attaboy_force_o rises after 15 cycles; yumi clears it next cycle.
REQ-037 SHALL check simultaneous: 3 queued, mispredict plus yumi same cycle -> head popped, queue empty next cycle, no attaboy for 2 cycles.
REQ-038 SHALL check nonbr: no site bits, src_btb=1, npc mismatch -> redirect_br_nonbr_o=1, taken/ntaken=0.
